// File: rtl/string_tx.sv
// Serialises a packed cell reference {op,row,col} into ASCII bytes ("AB105+") over a valid/ready link.
// Optional terminator byte is enabled by defining STRING_TX_TERM_EN.
module string_tx #(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [21:0] cell_in,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        err,
  output logic [2:0]  length
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_COL_DIV = 3'd2;
  localparam logic [2:0] S_ROW_HUN = 3'd3;
  localparam logic [2:0] S_ROW_TEN = 3'd4;
  localparam logic [2:0] S_EMIT    = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  logic [2:0] r_state;
  logic [9:0] r_col;   // column remainder after the base-26 division
  logic [4:0] r_q;     // high-letter quotient (0..26)
  logic [9:0] r_row;   // row remainder; ends as the units digit
  logic [3:0] r_hun;
  logic [3:0] r_ten;
  logic [1:0] r_op;
  logic [2:0] r_slot;
  logic       r_valid;
  logic [2:0] r_len;
  logic       r_err;

  logic [7:0][7:0] w_byte;
  logic [6:0]      w_en;
  logic [2:0]      w_next;
  logic            w_bad;

  // Fixed slot layout: hi, lo, hundreds, tens, units, op, terminator.
  always_comb begin
    w_byte    = '0;
    w_byte[0] = 8'h40 + {3'b000, r_q};
    w_byte[1] = 8'h40 + {3'b000, r_col[4:0]};
    w_byte[2] = 8'h30 + {4'b0000, r_hun};
    w_byte[3] = 8'h30 + {4'b0000, r_ten};
    w_byte[4] = 8'h30 + {4'b0000, r_row[3:0]};
    case (r_op)
      2'd0:    w_byte[5] = 8'h2F;
      2'd1:    w_byte[5] = 8'h5C;
      2'd2:    w_byte[5] = 8'h2B;
      default: w_byte[5] = 8'h00;
    endcase
    w_byte[6] = TERM_CHAR;
  end

  always_comb begin
    w_en[0] = (r_q != 5'd0);
    w_en[1] = 1'b1;
    w_en[2] = (r_hun != 4'd0);
    w_en[3] = (r_hun != 4'd0) || (r_ten != 4'd0);
    w_en[4] = 1'b1;
    w_en[5] = (r_op != 2'd3);
`ifdef STRING_TX_TERM_EN
    w_en[6] = 1'b1;
`else
    w_en[6] = 1'b0;
`endif
  end

  // Lowest enabled slot above the current one; 7 means the string is complete.
  always_comb begin
    w_next = 3'd7;
    for (int i = 6; i >= 0; i--)
      if (w_en[i] && (3'(i) > r_slot)) w_next = 3'(i);
  end

  assign w_bad = (r_col == 10'd0) || (r_col > 10'd702) || (r_row > 10'd999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_q     <= '0;
      r_row   <= '0;
      r_hun   <= '0;
      r_ten   <= '0;
      r_op    <= '0;
      r_slot  <= '0;
      r_valid <= 1'b0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_len <= '0;
          r_err <= 1'b0;
          if (start) begin
            r_col   <= cell_in[9:0];
            r_row   <= cell_in[19:10];
            r_op    <= cell_in[21:20];
            r_q     <= '0;
            r_hun   <= '0;
            r_ten   <= '0;
            r_slot  <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_COL_DIV;
          end
        end
        // Each stage leaves on its last subtraction so the worst case fits 45 cycles.
        S_COL_DIV: begin
          if (r_col > 10'd26) begin
            r_col <= r_col - 10'd26;
            r_q   <= r_q + 5'd1;
            if (r_col <= 10'd52) r_state <= S_ROW_HUN;
          end else begin
            r_state <= S_ROW_HUN;
          end
        end
        S_ROW_HUN: begin
          if (r_row >= 10'd100) begin
            r_row <= r_row - 10'd100;
            r_hun <= r_hun + 4'd1;
            if (r_row < 10'd200) r_state <= S_ROW_TEN;
          end else begin
            r_state <= S_ROW_TEN;
          end
        end
        S_ROW_TEN: begin
          if (r_row >= 10'd10) begin
            r_row <= r_row - 10'd10;
            r_ten <= r_ten + 4'd1;
          end
          if (r_row < 10'd20) begin
            r_state <= S_EMIT;
            r_valid <= 1'b1;
            r_slot  <= (r_q != 5'd0) ? 3'd0 : 3'd1;
          end
        end
        S_EMIT: begin
          if (tx_ready) begin
            r_len <= r_len + 3'd1;
            if (w_next == 3'd7) begin
              r_valid <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_slot <= w_next;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done     = (r_state == S_FIN);
  assign err      = done & r_err;
  assign length   = done ? r_len : 3'd0;
  assign tx_valid = r_valid;
  assign tx_data  = r_valid ? w_byte[r_slot] : 8'h00;

endmodule

// File: tb/tb_string_tx.sv
// Bench for string_tx: request table, byte scoreboard, plus busy-start and mid-string reset sequences.
module tb_string_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [21:0] cell_in;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;
  logic        err;
  logic [2:0]  length;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  string_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cell_in(cell_in), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .err(err), .length(length)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    col;
    int    row;
    int    op;
    int    mode;     // 0: ready=1, 1: toggle, 2: random
    string exp_s;
    bit    exp_err;
    bit    poke;     // re-issue start while busy
    int    max_lat;  // bound on start->first tx_valid
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int  cyc, exp_len, first_v;
    bit  seen_done, seen_valid, pv, pr;
    logic [7:0] pd;
    exp_len = v.exp_err ? 0 : v.exp_s.len();
    for (int i = 0; i < v.exp_s.len(); i++) sb_q.push_back(v.exp_s[i]);
`ifdef STRING_TX_TERM_EN
    if (!v.exp_err) begin
      sb_q.push_back(8'h0D);
      exp_len++;
    end
`endif
    @(negedge clk);
    cell_in = {v.op[1:0], v.row[9:0], v.col[9:0]};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cell_in = 22'h3FFFFF;
    seen_done = 0; seen_valid = 0; first_v = -1; pv = 0; pr = 0; pd = 0;
    for (cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (v.mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2) == 0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.poke && cyc == 3) begin
        start   = 1'b1;
        cell_in = {2'd0, 10'd5, 10'd3};
      end else begin
        start = 1'b0;
      end
      if (cyc == 0) chk("busy_after_start", busy, 1);
      if (pv && !pr) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      if (tx_valid) begin
        if (!seen_valid) first_v = cyc;
        seen_valid = 1;
        if (tx_ready) begin
          if (sb_q.size() == 0) chk("extra_byte", tx_data, 0);
          else chk("byte", tx_data, sb_q.pop_front());
        end
      end
      if (done) begin
        seen_done = 1;
        chk("done_err", err, v.exp_err);
        chk("done_len", length, exp_len);
        chk("done_busy", busy, 0);
        chk("bytes_left", sb_q.size(), 0);
        chk("valid_ever", seen_valid, !v.exp_err);
        if (!v.exp_err) chk("latency_ok", first_v <= v.max_lat, 1);
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    start = 1'b0;
    if (!seen_done) begin
      errors++;
      $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
    end
    sb_q.delete();
    @(negedge clk);
    chk("done_single", done, 0);
    repeat (3) @(negedge clk);
    chk("idle_after", {busy, tx_valid}, 0);
  endtask

  vec_t vt[$];

  initial begin
    int hs;
    vt.push_back('{1,   7,    0, 0, "A7/",      0, 0, 45});
    vt.push_back('{28,  105,  2, 1, "AB105+",   0, 0, 45});
    vt.push_back('{702, 999,  1, 0, "ZZ999\\",  0, 0, 45});
    vt.push_back('{0,   5,    0, 0, "",         1, 0, 45});
    vt.push_back('{703, 5,    0, 0, "",         1, 0, 45});
    vt.push_back('{5,   1000, 0, 0, "",         1, 0, 45});
    vt.push_back('{26,  0,    3, 0, "Z0",       0, 1, 45});
    vt.push_back('{27,  10,   2, 2, "AA10+",    0, 0, 45});
    vt.push_back('{52,  100,  0, 2, "AZ100/",   0, 0, 45});
    vt.push_back('{53,  99,   3, 1, "BA99",     0, 0, 45});

    rst_n = 1'b0; start = 1'b0; cell_in = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, tx_valid, done, err, length, tx_data}, 0);
    rst_n = 1'b1;

    foreach (vt[i]) run_req(vt[i]);

    // Reset while the third byte is stalled.
    @(negedge clk);
    cell_in = {2'd2, 10'd105, 10'd28};
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (tx_valid) begin
        if (hs == 2) begin
          tx_ready = 1'b0;
          break;
        end
        hs++;
      end
      @(negedge clk);
    end
    chk("third_byte", {tx_valid, tx_data}, {1'b1, 8'h31});
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req('{28, 105, 2, 0, "AB105+", 0, 0, 45});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
